doppler_velocity_estimator: RTL and testbench

DOPPLER_VELOCITY_ESTIMATOR -- requirements
Module: doppler_velocity_estimator

---
 rtl/doppler_pkg.sv | 17 +
 rtl/velocity_scaler.sv | 36 +++
 rtl/doppler_velocity_estimator.sv | 139 +++++++++++++
 tb/tb_doppler_velocity_estimator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/doppler_pkg.sv
// Shared definitions for the Doppler velocity estimator.
// Contents: FSM state encoding, Q1.15 fraction-bit count, and the
// 16-bit signed saturation bounds used by the velocity scaler.
package doppler_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCALE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int FRAC_BITS = 15;

  localparam logic signed [15:0] VEL_MAX = 16'sh7FFF;
  localparam logic signed [15:0] VEL_MIN = 16'sh8000;

endpackage

// File: rtl/velocity_scaler.sv
// Combinational phase-to-velocity conversion.
// Multiplies a 16-bit signed mean by the Q1.15 factor VEL_SCALE, drops the
// fraction bits with an arithmetic shift (floor), and saturates to 16 bits.
// Ports:
//   mean     in  16  signed averaged phase difference
//   velocity out 16  signed scaled, saturated velocity
module velocity_scaler
  import doppler_pkg::*;
#(
  parameter int VEL_SCALE = 16384
) (
  input  logic signed [15:0] mean,
  output logic signed [15:0] velocity
);

  localparam logic signed [15:0] SCALE_C = 16'(VEL_SCALE);

  logic signed [31:0] product;
  logic signed [31:0] shifted;

  // Both operands are signed and 16 bits, so the full product fits in 32 bits.
  assign product = mean * SCALE_C;
  assign shifted = product >>> FRAC_BITS;

  // Only -32768 * -32768 can exceed the positive bound; the negative check
  // is kept so the block stays correct for any factor.
  always_comb begin
    velocity = shifted[15:0];
    if (shifted > 32'(VEL_MAX)) begin
      velocity = VEL_MAX;
    end else if (shifted < 32'(VEL_MIN)) begin
      velocity = VEL_MIN;
    end
  end

endmodule

// File: rtl/doppler_velocity_estimator.sv
// Doppler velocity estimator.
// Averages 2^AVG_LOG2 phase-difference samples, scales the mean to a
// velocity, and holds the result until downstream accepts it. Samples that
// arrive while a result is pending are counted as drops. A partial window
// that sees GAP_MAX idle cycles in a row is discarded.
// Ports:
//   clk          in   1  clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   phase_diff   in  16  signed phase difference sample
//   diff_valid   in   1  phase_diff valid (no back-pressure upstream)
//   velocity     out 16  signed averaged, scaled velocity
//   vel_valid    out  1  velocity valid, held until accepted
//   vel_ready    in   1  downstream accept
//   window_abort out  1  one-cycle pulse when a partial window is dropped
//   drop_count   out  8  samples dropped while not accumulating (saturating)
module doppler_velocity_estimator
  import doppler_pkg::*;
#(
  parameter int AVG_LOG2  = 3,
  parameter int VEL_SCALE = 16384,
  parameter int GAP_MAX   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [15:0] phase_diff,
  input  logic               diff_valid,
  output logic signed [15:0] velocity,
  output logic               vel_valid,
  input  logic               vel_ready,
  output logic               window_abort,
  output logic [7:0]         drop_count
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int GAP_W = $clog2(GAP_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_MAX - 1);

  state_e                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic        [CNT_W-1:0]   cnt_q;
  logic        [GAP_W-1:0]   gap_q;
  logic signed [15:0]        velocity_q;
  logic                      vel_valid_q;
  logic                      window_abort_q;
  logic        [7:0]         drop_q;

  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [15:0]        mean;
  logic signed [15:0]        scaled;

  assign sample_ext = {{AVG_LOG2{phase_diff[15]}}, phase_diff};

  // Taking the upper 16 bits of the accumulator is the arithmetic right
  // shift by AVG_LOG2 (floor); the sum of N samples divided by N always
  // fits in 16 bits, so no bits are lost.
  assign mean = acc_q[AVG_LOG2 +: 16];

  velocity_scaler #(
    .VEL_SCALE (VEL_SCALE)
  ) u_scaler (
    .mean     (mean),
    .velocity (scaled)
  );

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the design holds no memories, so every state bit is cleared by
    // reset; a pending window or result never survives a reset.
    if (!reset_n) begin
      state_q        <= ST_ACCUM;
      acc_q          <= '0;
      cnt_q          <= '0;
      gap_q          <= '0;
      velocity_q     <= '0;
      vel_valid_q    <= 1'b0;
      window_abort_q <= 1'b0;
      drop_q         <= '0;
    end else begin
      window_abort_q <= 1'b0;

      case (state_q)
        ST_ACCUM: begin
          if (diff_valid) begin
            // A sample on the gap-limit cycle lands here and wins over abort.
            acc_q <= acc_q + sample_ext;
            cnt_q <= cnt_q + 1'b1;
            gap_q <= '0;
            if (cnt_q == LAST_SAMPLE) begin
              state_q <= ST_SCALE;
            end
          end else if (cnt_q != '0) begin
            if (gap_q == GAP_LAST) begin
              acc_q          <= '0;
              cnt_q          <= '0;
              gap_q          <= '0;
              window_abort_q <= 1'b1;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
        end

        ST_SCALE: begin
          velocity_q  <= scaled;
          vel_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end

        ST_HOLD: begin
          // vel_valid is always high in HOLD, so vel_ready alone completes
          // the handshake.
          if (vel_ready) begin
            vel_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            state_q     <= ST_ACCUM;
          end
        end

        default: state_q <= ST_ACCUM;
      endcase

      if ((state_q != ST_ACCUM) && diff_valid && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign velocity     = velocity_q;
  assign vel_valid    = vel_valid_q;
  assign window_abort = window_abort_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_doppler_velocity_estimator.sv
// Directed testbench for doppler_velocity_estimator: a default-parameter
// instance driven by a table of full windows plus hand-written corner
// sequences, and a second instance configured for the saturation case.
module tb_doppler_velocity_estimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic               reset_n;
  logic signed [15:0] phase_diff;
  logic               diff_valid;
  logic signed [15:0] velocity;
  logic               vel_valid;
  logic               vel_ready;
  logic               window_abort;
  logic [7:0]         drop_count;

  // Saturation instance
  logic signed [15:0] s_phase_diff;
  logic               s_diff_valid;
  logic signed [15:0] s_velocity;
  logic               s_vel_valid;
  logic               s_vel_ready;
  logic               s_window_abort;
  logic [7:0]         s_drop_count;

  doppler_velocity_estimator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .phase_diff   (phase_diff),
    .diff_valid   (diff_valid),
    .velocity     (velocity),
    .vel_valid    (vel_valid),
    .vel_ready    (vel_ready),
    .window_abort (window_abort),
    .drop_count   (drop_count)
  );

  doppler_velocity_estimator #(
    .AVG_LOG2  (1),
    .VEL_SCALE (-32768),
    .GAP_MAX   (64)
  ) dut_sat (
    .clk          (clk),
    .reset_n      (reset_n),
    .phase_diff   (s_phase_diff),
    .diff_valid   (s_diff_valid),
    .velocity     (s_velocity),
    .vel_valid    (s_vel_valid),
    .vel_ready    (s_vel_ready),
    .window_abort (s_window_abort),
    .drop_count   (s_drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic signed [15:0] sample;
    logic signed [15:0] exp_vel;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed eight equal samples, then check the SCALE cycle and the result.
  task automatic run_window(input logic signed [15:0] val,
                            input logic signed [15:0] exp_vel,
                            input string tag);
    for (int i = 0; i < 8; i++) begin
      phase_diff = val;
      diff_valid = 1'b1;
      tick();
    end
    diff_valid = 1'b0;
    check({tag, "_valid_low_after_last"}, vel_valid, 0);
    tick();
    check({tag, "_valid_high"}, vel_valid, 1);
    check({tag, "_velocity"}, velocity, exp_vel);
  endtask

  task automatic accept();
    vel_ready = 1'b1;
    tick();
    vel_ready = 1'b0;
    check("handshake_clears_valid", vel_valid, 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    check("reset_velocity", velocity, 0);
    check("reset_vel_valid", vel_valid, 0);
    check("reset_window_abort", window_abort, 0);
    check("reset_drop_count", drop_count, 0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int aborts;

    // mean*16384 >>> 15 is floor(mean/2)
    vecs[0] = '{sample: 16'sd1000,   exp_vel: 16'sd500};
    vecs[1] = '{sample: -16'sd3,     exp_vel: -16'sd2};
    vecs[2] = '{sample: 16'sd200,    exp_vel: 16'sd100};
    vecs[3] = '{sample: 16'sd0,      exp_vel: 16'sd0};
    vecs[4] = '{sample: 16'sd32767,  exp_vel: 16'sd16383};
    vecs[5] = '{sample: -16'sd32768, exp_vel: -16'sd16384};
    vecs[6] = '{sample: -16'sd1,     exp_vel: -16'sd1};

    reset_n      = 1'b0;
    phase_diff   = '0;
    diff_valid   = 1'b0;
    vel_ready    = 1'b0;
    s_phase_diff = '0;
    s_diff_valid = 1'b0;
    s_vel_ready  = 1'b0;
    #2;
    check("init_velocity", velocity, 0);
    check("init_vel_valid", vel_valid, 0);
    check("init_drop_count", drop_count, 0);
    check("init_window_abort", window_abort, 0);
    #10;
    reset_n = 1'b1;
    tick();

    // Table-driven windows
    for (int v = 0; v < 7; v++) begin
      run_window(vecs[v].sample, vecs[v].exp_vel, $sformatf("vec%0d", v));
      accept();
    end
    check("no_drops_after_table", drop_count, 0);

    // Back-pressure: result held, samples dropped, fresh window afterwards
    run_window(16'sd1000, 16'sd500, "bp");
    for (int i = 0; i < 10; i++) begin
      diff_valid = (i % 2 == 0);
      phase_diff = 16'sd7777;
      tick();
      check("bp_velocity_stable", velocity, 500);
      check("bp_valid_held", vel_valid, 1);
    end
    diff_valid = 1'b0;
    check("bp_drop_count", drop_count, 5);
    // A sample on the handshake cycle is also dropped.
    vel_ready  = 1'b1;
    diff_valid = 1'b1;
    tick();
    vel_ready  = 1'b0;
    diff_valid = 1'b0;
    check("bp_handshake_valid_low", vel_valid, 0);
    check("bp_handshake_drop", drop_count, 6);
    run_window(-16'sd3, -16'sd2, "bp_next");
    accept();

    // Gap abort: 3 samples then 64 idle cycles
    for (int i = 0; i < 3; i++) begin
      phase_diff = 16'sd50;
      diff_valid = 1'b1;
      tick();
    end
    diff_valid = 1'b0;
    aborts = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (window_abort) aborts++;
    end
    check("gap_no_early_abort", aborts, 0);
    tick();
    check("gap_abort_pulse", window_abort, 1);
    tick();
    check("gap_abort_one_cycle", window_abort, 0);
    run_window(16'sd200, 16'sd100, "gap_next");
    accept();

    // Sample on the gap-limit cycle is accepted, no abort
    for (int i = 0; i < 3; i++) begin
      phase_diff = 16'sd80;
      diff_valid = 1'b1;
      tick();
    end
    diff_valid = 1'b0;
    aborts = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (window_abort) aborts++;
    end
    for (int i = 0; i < 5; i++) begin
      phase_diff = 16'sd80;
      diff_valid = 1'b1;
      tick();
      if (window_abort) aborts++;
    end
    diff_valid = 1'b0;
    check("edge_gap_no_abort", aborts, 0);
    check("edge_gap_valid_low", vel_valid, 0);
    tick();
    check("edge_gap_valid_high", vel_valid, 1);
    check("edge_gap_velocity", velocity, 40);
    accept();

    // Reset mid-window discards the partial sum and the drop count
    for (int i = 0; i < 4; i++) begin
      phase_diff = 16'sd999;
      diff_valid = 1'b1;
      tick();
    end
    diff_valid = 1'b0;
    pulse_reset();
    tick();
    run_window(16'sd400, 16'sd200, "rst_mid");
    check("rst_mid_drop_count", drop_count, 0);
    accept();

    // Reset while holding a result
    run_window(16'sd700, 16'sd350, "rst_hold_pre");
    pulse_reset();
    tick();
    check("rst_hold_still_idle", vel_valid, 0);
    run_window(16'sd400, 16'sd200, "rst_hold");
    accept();

    // Saturation instance: two samples per window, factor -1.0
    for (int i = 0; i < 2; i++) begin
      s_phase_diff = -16'sd32768;
      s_diff_valid = 1'b1;
      tick();
    end
    s_diff_valid = 1'b0;
    check("sat_valid_low_after_last", s_vel_valid, 0);
    tick();
    check("sat_valid_high", s_vel_valid, 1);
    check("sat_velocity_pos", s_velocity, 32767);
    s_vel_ready = 1'b1;
    tick();
    s_vel_ready = 1'b0;
    check("sat_handshake", s_vel_valid, 0);
    for (int i = 0; i < 2; i++) begin
      s_phase_diff = 16'sd16384;
      s_diff_valid = 1'b1;
      tick();
    end
    s_diff_valid = 1'b0;
    tick();
    check("sat_velocity_neg", s_velocity, -16384);
    s_vel_ready = 1'b1;
    tick();
    s_vel_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_phase_diff = 16'sd32767;
      s_diff_valid = 1'b1;
      tick();
    end
    s_diff_valid = 1'b0;
    tick();
    check("sat_velocity_max_in", s_velocity, -32767);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
